// File: rtl/dst_writeback.sv
// dst_writeback: write-back end of the destination-select path.
//
// Accepts {select, data} write requests over a valid/ready handshake and commits
// each one into one of four destination registers A-D. While WB_HOLD is high,
// commits are frozen and accepted requests queue in a DEPTH-entry in-order FIFO.
// Once hold drops, the queue drains one entry per cycle. An empty queue lets a
// new request commit directly (cut-through) without being enqueued.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   WB_VALID/WB_READY   request handshake; READY depends only on FIFO occupancy
//   WB_SEL, WB_DATA     destination select (0=A..3=D) and write data
//   WB_HOLD             freeze commits; requests may still be queued
//   DST_A..DST_D        destination registers feeding the destination mux
//   WB_COMMIT           one-cycle pulse after the edge that performed a commit
//   WB_COMMIT_SEL       register written by the most recent commit (sticky)
//   WB_PENDING          FIFO non-empty
//   WB_COUNT            FIFO occupancy, zero-extended to 5 bits

module dst_writeback #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WB_VALID,
  output logic                  WB_READY,
  input  logic [1:0]            WB_SEL,
  input  logic [DATA_WIDTH-1:0] WB_DATA,
  input  logic                  WB_HOLD,
  output logic [DATA_WIDTH-1:0] DST_A,
  output logic [DATA_WIDTH-1:0] DST_B,
  output logic [DATA_WIDTH-1:0] DST_C,
  output logic [DATA_WIDTH-1:0] DST_D,
  output logic                  WB_COMMIT,
  output logic [1:0]            WB_COMMIT_SEL,
  output logic                  WB_PENDING,
  output logic [4:0]            WB_COUNT
);

  localparam int unsigned PtrW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = 5;
  localparam int unsigned EntryW = DATA_WIDTH + 2;

  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // FIFO state
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // Destination registers and commit status
  logic [DATA_WIDTH-1:0] dst_q [4];
  logic [DATA_WIDTH-1:0] dst_d [4];
  logic                  commit_q, commit_d;
  logic [1:0]            commit_sel_q, commit_sel_d;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  do_commit;
  logic [1:0]            cm_sel;
  logic [DATA_WIDTH-1:0] cm_data;
  logic                  fifo_empty;
  logic [EntryW-1:0]     head;

  assign fifo_empty = (count_q == '0);
  assign WB_READY   = (count_q != CntFull);
  assign accept     = WB_VALID && WB_READY;
  assign head       = mem_q[rd_ptr_q];

  // Commit source selection: hold > queued head > cut-through.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    do_commit = 1'b0;
    cm_sel    = head[EntryW-1 -: 2];
    cm_data   = head[DATA_WIDTH-1:0];
    if (WB_HOLD) begin
      push = accept;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      push      = accept;
      do_commit = 1'b1;
    end else if (accept) begin
      // Empty queue: the request bypasses the FIFO entirely.
      do_commit = 1'b1;
      cm_sel    = WB_SEL;
      cm_data   = WB_DATA;
    end
  end

  // Pointer and occupancy update; wrap is an explicit compare so non-power-of-two
  // depths work.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dst_d[i] = dst_q[i];
    end
    commit_d     = do_commit;
    commit_sel_d = commit_sel_q;
    if (do_commit) begin
      dst_d[cm_sel] = cm_data;
      commit_sel_d  = cm_sel;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      commit_q     <= 1'b0;
      commit_sel_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        dst_q[i] <= '0;
      end
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      commit_q     <= commit_d;
      commit_sel_q <= commit_sel_d;
      for (int i = 0; i < 4; i++) begin
        dst_q[i] <= dst_d[i];
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {WB_SEL, WB_DATA};
    end
  end

  assign DST_A         = dst_q[0];
  assign DST_B         = dst_q[1];
  assign DST_C         = dst_q[2];
  assign DST_D         = dst_q[3];
  assign WB_COMMIT     = commit_q;
  assign WB_COMMIT_SEL = commit_sel_q;
  assign WB_PENDING    = !fifo_empty;
  assign WB_COUNT      = count_q;

endmodule
